// File: rtl/motor_ramp_controller.sv
`default_nettype none
// ============================================================================
// Module      : motor_ramp_controller
// Description : Soft-start/soft-stop speed ramp with safe direction reversal.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_ramp_controller #(
    parameter int STEP_DIV  = 50000,
    parameter int STEP_SIZE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] target_speed,
    input  logic       target_dir,
    input  logic       load,
    output logic [7:0] set_speed,
    output logic       motor_dir,
    output logic       busy,
    output logic       done
);

    localparam int              c_PW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(STEP_DIV - 1);
    localparam logic [c_PW-1:0] c_PRE_ONE  = c_PW'(1);
    localparam logic [8:0]      c_STEP     = 9'(STEP_SIZE);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_UP      = 2'd1;
    localparam logic [1:0] c_S_DOWN    = 2'd2;
    localparam logic [1:0] c_S_REVERSE = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [7:0]      r_tgt_spd;
    logic            r_tgt_dir;
    logic [c_PW-1:0] r_prescaler;
    logic [7:0]      r_set_speed;
    logic            r_motor_dir;
    logic            r_busy;
    logic            r_done;

    logic            w_tick;
    logic [8:0]      w_up_sum;
    logic [8:0]      w_dn_diff;
    logic [7:0]      w_speed_nxt;
    logic            w_dir_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    assign w_tick = (r_state != c_S_IDLE) && (r_prescaler == c_PRE_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: a pending direction change dominates, even at zero speed
    always_comb begin
        w_next_state = c_S_IDLE;
        if (r_motor_dir != r_tgt_dir) begin
            w_next_state = c_S_REVERSE;
        end else if (r_set_speed < r_tgt_spd) begin
            w_next_state = c_S_UP;
        end else if (r_set_speed > r_tgt_spd) begin
            w_next_state = c_S_DOWN;
        end
    end

    // Output/datapath next values; sums are 9 bits so clamping sees overflow
    always_comb begin
        w_up_sum    = {1'b0, r_set_speed} + c_STEP;
        w_dn_diff   = {1'b0, r_set_speed} - c_STEP;
        w_speed_nxt = r_set_speed;
        w_dir_nxt   = r_motor_dir;
        if (w_tick) begin
            case (r_state)
                c_S_UP: begin
                    w_speed_nxt = (w_up_sum > {1'b0, r_tgt_spd}) ? r_tgt_spd : w_up_sum[7:0];
                end
                c_S_DOWN: begin
                    w_speed_nxt = (w_dn_diff[8] || (w_dn_diff[7:0] < r_tgt_spd))
                                  ? r_tgt_spd : w_dn_diff[7:0];
                end
                c_S_REVERSE: begin
                    // Direction only flips after a full step period parked at zero
                    if (r_set_speed != 8'd0) begin
                        w_speed_nxt = w_dn_diff[8] ? 8'd0 : w_dn_diff[7:0];
                    end else begin
                        w_dir_nxt = r_tgt_dir;
                    end
                end
                default: begin
                    w_speed_nxt = r_set_speed;
                end
            endcase
        end
        w_busy_nxt = (w_next_state != c_S_IDLE);
        w_done_nxt = (r_state != c_S_IDLE) && (w_next_state == c_S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tgt_spd   <= 8'd0;
            r_tgt_dir   <= 1'b0;
            r_prescaler <= '0;
            r_set_speed <= 8'd0;
            r_motor_dir <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (load) begin
                r_tgt_spd <= target_speed;
                r_tgt_dir <= target_dir;
            end
            if ((r_state == c_S_IDLE) || w_tick) begin
                r_prescaler <= '0;
            end else begin
                r_prescaler <= r_prescaler + c_PRE_ONE;
            end
            r_set_speed <= w_speed_nxt;
            r_motor_dir <= w_dir_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign set_speed = r_set_speed;
    assign motor_dir = r_motor_dir;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_motor_ramp_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_ramp_controller
// Description : Scoreboard bench for motor_ramp_controller (STEP_DIV=4, STEP_SIZE=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_ramp_controller;

    localparam int DIV  = 4;
    localparam int STEP = 16;

    logic       clk          = 1'b0;
    logic       rst          = 1'b1;
    logic [7:0] target_speed = 8'd0;
    logic       target_dir   = 1'b0;
    logic       load         = 1'b0;
    logic [7:0] set_speed;
    logic       motor_dir;
    logic       busy;
    logic       done;

    motor_ramp_controller #(
        .STEP_DIV  (DIV),
        .STEP_SIZE (STEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .target_speed (target_speed),
        .target_dir   (target_dir),
        .load         (load),
        .set_speed    (set_speed),
        .motor_dir    (motor_dir),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] spd;
        logic       dir;
    } ev_t;

    ev_t        exp_q[$];
    int         done_q[$];
    int         cyc      = 0;
    int         errors   = 0;
    int         checks   = 0;
    logic [7:0] prev_spd = 8'd0;
    logic       prev_dir = 1'b0;
    int         cur_spd  = 0;
    logic       cur_dir  = 1'b0;

    // cyc equals the index of the most recent rising edge when read at a negedge
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        ev_t ev;
        int  dexp;
        if (!rst) begin
            if (set_speed !== prev_spd || motor_dir !== prev_dir) begin
                if (motor_dir !== prev_dir) begin
                    checks = checks + 1;
                    assert (prev_spd === 8'd0 && set_speed === 8'd0) else begin
                        errors = errors + 1;
                        $error("FAIL dir_flip_nonzero: observed speed %0d->%0d at cycle %0d, expected 0", prev_spd, set_speed, cyc);
                    end
                end
                checks = checks + 1;
                assert (exp_q.size() != 0) else begin
                    errors = errors + 1;
                    $error("FAIL unexpected_step: observed speed=%0d dir=%0b at cycle %0d, expected no change", set_speed, motor_dir, cyc);
                end
                if (exp_q.size() != 0) begin
                    ev = exp_q.pop_front();
                    checks = checks + 1;
                    assert (cyc === ev.cyc && set_speed === ev.spd && motor_dir === ev.dir) else begin
                        errors = errors + 1;
                        $error("FAIL step: observed speed=%0d dir=%0b cyc=%0d, expected speed=%0d dir=%0b cyc=%0d", set_speed, motor_dir, cyc, ev.spd, ev.dir, ev.cyc);
                    end
                end
                prev_spd = set_speed;
                prev_dir = motor_dir;
            end
            if (done === 1'b1) begin
                checks = checks + 1;
                assert (done_q.size() != 0) else begin
                    errors = errors + 1;
                    $error("FAIL unexpected_done: observed done=1 at cycle %0d, expected 0", cyc);
                end
                if (done_q.size() != 0) begin
                    dexp = done_q.pop_front();
                    checks = checks + 1;
                    assert (cyc === dexp) else begin
                        errors = errors + 1;
                        $error("FAIL done_cycle: observed %0d, expected %0d", cyc, dexp);
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input int c, input int s, input logic d);
        ev_t e;
        e.cyc = c;
        e.spd = 8'(s);
        e.dir = d;
        exp_q.push_back(e);
    endtask

    // Reference ramp: down to zero and flip if needed, then step toward target
    task automatic plan(input int t, input logic td, input int first);
        int   s;
        logic d;
        int   e;
        s = cur_spd;
        d = cur_dir;
        e = first;
        if (d != td) begin
            while (s > 0) begin
                s = (s > STEP) ? s - STEP : 0;
                push_ev(e, s, d);
                e = e + DIV;
            end
            d = td;
            push_ev(e, 0, d);
            e = e + DIV;
        end
        while (s != t) begin
            if (s < t) s = (s + STEP > t) ? t : s + STEP;
            else       s = (s - STEP < t) ? t : s - STEP;
            push_ev(e, s, d);
            e = e + DIV;
        end
        if (e != first) done_q.push_back(e - DIV + 1);
        cur_spd = t;
        cur_dir = td;
    endtask

    // Called at a negedge; the target is latched on the next rising edge
    task automatic do_load(input int t, input logic td, input bit model);
        target_speed = 8'(t);
        target_dir   = td;
        load         = 1'b1;
        if (model) plan(t, td, cyc + 2 + DIV);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_quiet(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || busy !== 1'b0) && n < limit) begin
            @(negedge clk);
            n = n + 1;
        end
        repeat (3) @(negedge clk);
        checks = checks + 1;
        assert (exp_q.size() == 0 && done_q.size() == 0 && busy === 1'b0) else begin
            errors = errors + 1;
            $error("FAIL settle: observed pending=%0d done_pending=%0d busy=%0b, expected 0 0 0", exp_q.size(), done_q.size(), busy);
        end
    endtask

    initial begin
        int   n0;
        logic seen;

        #12;
        check("rst_speed", 32'(set_speed), 32'd0);
        check("rst_dir",   32'(motor_dir), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Ramp up from zero
        do_load(100, 1'b0, 1'b1);
        @(negedge clk);
        check("busy_rise", 32'(busy), 32'd1);
        wait_quiet(100);
        check("t1_dir", 32'(motor_dir), 32'd0);

        // Saturation at both ends
        do_load(255, 1'b0, 1'b1);
        wait_quiet(200);
        check("t2_top", 32'(set_speed), 32'd255);
        do_load(0, 1'b0, 1'b1);
        wait_quiet(200);
        check("t2_bottom", 32'(set_speed), 32'd0);

        // Reversal with dwell at zero
        do_load(64, 1'b0, 1'b1);
        wait_quiet(100);
        do_load(32, 1'b1, 1'b1);
        wait_quiet(150);
        check("t3_dir", 32'(motor_dir), 32'd1);
        check("t3_speed", 32'(set_speed), 32'd32);

        // Retarget mid-ramp keeps cadence
        n0 = cyc + 1;
        push_ev(n0 + 5, 48, 1'b1);
        push_ev(n0 + 9, 64, 1'b1);
        do_load(200, 1'b1, 1'b0);
        while (cyc != n0 + 9) @(negedge clk);
        check("t4_at64", 32'(set_speed), 32'd64);
        push_ev(n0 + 13, 48, 1'b1);
        push_ev(n0 + 17, 40, 1'b1);
        done_q.push_back(n0 + 18);
        cur_spd = 40;
        do_load(40, 1'b1, 1'b0);
        wait_quiet(100);

        // Null load: no busy, no done
        do_load(40, 1'b1, 1'b1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | busy;
        end
        check("null_busy", 32'(seen), 32'd0);

        // Load coincident with a tick: that step still uses the old target
        n0 = cyc + 1;
        push_ev(n0 + 5, 56, 1'b1);
        push_ev(n0 + 9, 72, 1'b1);
        do_load(100, 1'b1, 1'b0);
        while (cyc != n0 + 8) @(negedge clk);
        push_ev(n0 + 13, 60, 1'b1);
        done_q.push_back(n0 + 14);
        cur_spd = 60;
        do_load(60, 1'b1, 1'b0);
        wait_quiet(100);

        // Asynchronous reset mid-ramp
        do_load(80, 1'b1, 1'b1);
        wait_quiet(100);
        do_load(200, 1'b1, 1'b1);
        @(negedge clk);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_speed80", 32'(set_speed), 32'd80);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_speed", 32'(set_speed), 32'd0);
        check("t5_rst_dir",   32'(motor_dir), 32'd0);
        check("t5_rst_busy",  32'(busy),      32'd0);
        exp_q.delete();
        done_q.delete();
        prev_spd = 8'd0;
        prev_dir = 1'b0;
        cur_spd  = 0;
        cur_dir  = 1'b0;
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | busy;
        end
        check("t5_idle_busy", 32'(seen), 32'd0);
        check("t5_idle_speed", 32'(set_speed), 32'd0);

        // Normal operation resumes after reset
        do_load(32, 1'b0, 1'b1);
        wait_quiet(100);
        check("t5_resume", 32'(set_speed), 32'd32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
